// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-stage load/store responder for the pipelined core. A request is
//   accepted in IDLE. resp_valid pulses LATENCY cycles later, in the RESP
//   state. Loads are read combinationally from the array during RESP. Stores
//   commit on the clock edge that ends RESP, so a following load to the same
//   address sees the new data. The responder does the RV32I lane selection,
//   the sign/zero extension and the byte-enable writes.
//
//   Optional feature macro: DMEM_ERR_CHECK_EN
//     defined   : misaligned accesses and illegal funct3 codes raise resp_err.
//                 They do not write the array and return zero data.
//     undefined : resp_err is always 0. Addresses are aligned down to the
//                 access size. Illegal load funct3 acts as LW and illegal
//                 store funct3 acts as SW.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             busy
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  w_accept;

  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;

  logic [WIDTH-1:0]      r_mem [DEPTH];

  size_t                 w_size;
  logic                  w_unsigned;
  logic                  w_illegal;
  logic                  w_misalign;
  logic                  w_err;
  logic [1:0]            w_lane;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [WIDTH-1:0]      w_word;
  logic [WIDTH-1:0]      w_shift;
  logic [WIDTH-1:0]      w_load_data;
  logic [WIDTH-1:0]      w_wdata_lane;
  logic [NB-1:0]         w_be;
  logic                  w_wr_en;

  // The address bits above ADDR_WIDTH are ignored, so accesses wrap.
  logic                  w_unused_addr_hi;
  assign w_unused_addr_hi = ^req_addr[WIDTH-1:ADDR_WIDTH];

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // State and latency-counter register.
  // NOTE: Sequential state uses non-blocking (<=) assignments only. Every
  // flop then samples values from before the edge, whatever order the blocks
  // are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic, counter update and handshake outputs.
  // NOTE: Every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    busy         = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_cnt_next   = 4'(LATENCY - 1);
          w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        busy       = 1'b1;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        busy         = 1'b1;
        resp_valid   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Request capture. The fields are held until the response completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr[ADDR_WIDTH-1:0];
      r_wdata  <= req_wdata;
    end
  end

  // Decode funct3 into access size and signedness, and flag illegal codes.
  always_comb begin
    w_size     = SZ_WORD;
    w_unsigned = 1'b0;
    w_illegal  = 1'b0;
    if (r_we) begin
      case (r_funct3)
        3'b000:  w_size = SZ_BYTE;
        3'b001:  w_size = SZ_HALF;
        3'b010:  w_size = SZ_WORD;
        default: begin
          w_size = SZ_WORD;
`ifdef DMEM_ERR_CHECK_EN
          w_illegal = 1'b1;
`endif
        end
      endcase
    end else begin
      case (r_funct3)
        3'b000:  w_size = SZ_BYTE;
        3'b001:  w_size = SZ_HALF;
        3'b010:  w_size = SZ_WORD;
        3'b100: begin
          w_size     = SZ_BYTE;
          w_unsigned = 1'b1;
        end
        3'b101: begin
          w_size     = SZ_HALF;
          w_unsigned = 1'b1;
        end
        default: begin
          w_size = SZ_WORD;
`ifdef DMEM_ERR_CHECK_EN
          w_illegal = 1'b1;
`endif
        end
      endcase
    end
  end

  // Select the byte lane, and detect misalignment or align the address down.
  always_comb begin
    w_misalign = 1'b0;
    w_lane     = r_addr[1:0];
`ifdef DMEM_ERR_CHECK_EN
    case (w_size)
      SZ_HALF: w_misalign = r_addr[0];
      SZ_WORD: w_misalign = (r_addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
`else
    case (w_size)
      SZ_HALF: w_lane = {r_addr[1], 1'b0};
      SZ_WORD: w_lane = 2'b00;
      default: w_lane = r_addr[1:0];
    endcase
`endif
  end

  assign w_err  = w_illegal | w_misalign;
  assign w_idx  = r_addr[ADDR_WIDTH-1:2];
  assign w_word = r_mem[w_idx];

  // Load path: move the addressed lane down to bit 0, then extend it.
  always_comb begin
    w_shift     = w_word >> {w_lane, 3'b000};
    w_load_data = w_shift;
    case (w_size)
      SZ_BYTE: w_load_data = {{(WIDTH-8){w_shift[7] & ~w_unsigned}}, w_shift[7:0]};
      SZ_HALF: w_load_data = {{(WIDTH-16){w_shift[15] & ~w_unsigned}}, w_shift[15:0]};
      default: w_load_data = w_shift;
    endcase
  end

  // Store path: move the store data up to its lane, and build the byte enables.
  always_comb begin
    w_wdata_lane = r_wdata << {w_lane, 3'b000};
    case (w_size)
      SZ_BYTE: w_be = NB'(1) << w_lane;
      SZ_HALF: w_be = NB'(3) << w_lane;
      default: w_be = '1;
    endcase
  end

  // A store commits only on the edge that leaves RESP. An async reset forces
  // the state to IDLE, so a reset during the access suppresses the write.
  assign w_wr_en = (r_state == S_RESP) && r_we && !w_err;

  // Byte-enabled write into the data array.
  // NOTE: The memory array has no reset. Its contents are undefined until
  // written, and leaving out the reset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_wdata_lane[b*8 +: 8];
        end
      end
    end
  end

  // Response data and error are meaningful only while resp_valid is high.
  always_comb begin
    resp_rdata = '0;
    resp_err   = 1'b0;
    if (r_state == S_RESP) begin
      resp_err = w_err;
      if (!r_we && !w_err) begin
        resp_rdata = w_load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed bench for data_mem_responder (WIDTH=32, ADDR_WIDTH=12,
//   LATENCY=2). Expected values are computed by hand. Where the optional
//   DMEM_ERR_CHECK_EN feature changes a result, both expected values are
//   listed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int LAT = 2;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(
    .WIDTH(32),
    .ADDR_WIDTH(12),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request, wait for its response, and return data, error and
  // the number of cycles from acceptance to resp_valid.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int n;
    rd  = '0;
    er  = 1'b0;
    lat = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h: req_ready never rose", addr);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h: no resp_valid within %0d cycles", addr, lat);
      return;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    checks++;
    if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++;
    if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    access(1'b1, 3'b010, 32'h10, 32'h0BADF00D, rd, er, lat);
    // Accept the store, then assert reset in the following WAIT cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy_before got=%b exp=1", busy); end
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, busy} !== 4'b1000 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midwait_reset_outputs got ready=%b valid=%b err=%b busy=%b rdata=%h exp 1 0 0 0 0",
               req_ready, resp_valid, resp_err, busy, resp_rdata);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midwait_no_resp got=%0d pulses exp=0", pulses); end
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL midwait_prior_data got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_bytes();
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(1'b1, 3'b010, 32'h20, 32'h80FF7F01, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw20_resp got rd=%h err=%b exp 0 0", rd, er); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL sw20_latency got=%0d exp=%0d", lat, LAT); end
    access(1'b0, 3'b000, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000001) begin errors++; $display("FAIL lb20 got=%h exp=00000001", rd); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL lb20_latency got=%0d exp=%0d", lat, LAT); end
    access(1'b0, 3'b000, 32'h23, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb23 got=%h exp=ffffff80", rd); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL lb23_latency got=%0d exp=%0d", lat, LAT); end
    access(1'b0, 3'b100, 32'h23, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu23 got=%h exp=00000080", rd); end
    access(1'b0, 3'b000, 32'h21, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000007F) begin errors++; $display("FAIL lb21 got=%h exp=0000007f", rd); end
    access(1'b0, 3'b100, 32'h22, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h000000FF) begin errors++; $display("FAIL lbu22 got=%h exp=000000ff", rd); end
  endtask

  task automatic test_halves();
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(1'b1, 3'b010, 32'h40, 32'h11223344, rd, er, lat);
    access(1'b1, 3'b001, 32'h42, 32'h0000ABCD, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sh42_resp got rd=%h err=%b exp 0 0", rd, er); end
    access(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hABCD3344) begin errors++; $display("FAIL lw40_after_sh got=%h exp=abcd3344", rd); end
    access(1'b0, 3'b001, 32'h42, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFABCD) begin errors++; $display("FAIL lh42 got=%h exp=ffffabcd", rd); end
    access(1'b0, 3'b101, 32'h42, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL lhu42 got=%h exp=0000abcd", rd); end
    access(1'b1, 3'b000, 32'h41, 32'h000000EE, rd, er, lat);
    access(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hABCDEE44) begin errors++; $display("FAIL sb41_merge got=%h exp=abcdee44", rd); end
    access(1'b1, 3'b000, 32'h41, 32'h00000033, rd, er, lat);
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic        er;
    int          lat;
    // Word 0x40 holds 0xABCD3344 here.
    access(1'b0, 3'b010, 32'h41, 32'h0, rd, er, lat);
    checks++;
    if (er !== ERR_EN) begin errors++; $display("FAIL lw41_err got=%b exp=%b", er, ERR_EN); end
    checks++;
    if (rd !== (ERR_EN ? 32'h0 : 32'hABCD3344)) begin errors++; $display("FAIL lw41_data got=%h", rd); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL lw41_latency got=%0d exp=%0d", lat, LAT); end
    access(1'b1, 3'b001, 32'h43, 32'h00005A5A, rd, er, lat);
    checks++;
    if (er !== ERR_EN || rd !== 32'h0) begin errors++; $display("FAIL sh43_resp got err=%b rd=%h exp err=%b rd=0", er, rd, ERR_EN); end
    access(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (rd !== (ERR_EN ? 32'hABCD3344 : 32'h5A5A3344)) begin errors++; $display("FAIL lw40_after_sh43 got=%h", rd); end
    access(1'b0, 3'b011, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (er !== ERR_EN || rd !== (ERR_EN ? 32'h0 : 32'h5A5A3344)) begin
      errors++; $display("FAIL illegal_load got err=%b rd=%h", er, rd);
    end
    access(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, rd, er, lat);
    checks++;
    if (er !== ERR_EN) begin errors++; $display("FAIL illegal_store_err got=%b exp=%b", er, ERR_EN); end
    access(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (rd !== (ERR_EN ? 32'hABCD3344 : 32'hFFFFFFFF)) begin errors++; $display("FAIL lw40_after_illegal got=%h", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(1'b1, 3'b010, 32'h1004, 32'h12345678, rd, er, lat);
    access(1'b0, 3'b010, 32'h0004, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap_lw4 got=%h exp=12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    int          acc   [3];
    int          n_acc, n_resp, busy_cnt, overlap;
    logic        acc_flag;
    addrs[0] = 32'h10; exps[0] = 32'h0BADF00D;
    addrs[1] = 32'h20; exps[1] = 32'h80FF7F01;
    addrs[2] = 32'h04; exps[2] = 32'h12345678;
    n_acc = 0; n_resp = 0; busy_cnt = 0; overlap = 0; acc_flag = 1'b0;
    for (int i = 0; i < 3; i++) acc[i] = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = addrs[0]; req_wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready && req_valid) begin
        if (n_acc < 3) acc[n_acc] = c;
        n_acc++;
        acc_flag = 1'b1;
      end
      if (resp_valid) begin
        if (n_resp < 3) begin
          checks++;
          if (resp_rdata !== exps[n_resp]) begin
            errors++;
            $display("FAIL b2b_data%0d got=%h exp=%h", n_resp, resp_rdata, exps[n_resp]);
          end
        end
        n_resp++;
      end
      if (busy) busy_cnt++;
      if (busy && req_ready) overlap++;
      @(negedge clk);
      if (acc_flag) begin
        if (n_acc < 3) req_addr = addrs[n_acc];
        else req_valid = 1'b0;
        acc_flag = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (n_acc != 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", n_acc); end
    checks++;
    if (n_resp != 3) begin errors++; $display("FAIL b2b_resps got=%0d exp=3", n_resp); end
    checks++;
    if (acc[1] - acc[0] != LAT + 1 || acc[2] - acc[1] != LAT + 1) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d,%0d,%0d exp spacing %0d", acc[0], acc[1], acc[2], LAT + 1);
    end
    checks++;
    if (busy_cnt != 3 * LAT) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy_cnt, 3 * LAT); end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL b2b_ready_while_busy got=%0d exp=0", overlap); end
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset_mid_wait();
    test_bytes();
    test_halves();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
